serial_adder_seq: RTL
=====================

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 SHALL have the port list below, clock and reset first; all outputs registered.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand transfer request.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  8  operand A, sampled on accept.
REQ-007 b  input  8  operand B, sampled on accept.
REQ-008 cin  input  1  carry-in, sampled on accept.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  8  result bits [7:0].
REQ-012 cout  output  1  carry-out (result bit 8).
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-015 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-016 Accept = in_valid && in_ready at an edge; SHALL load a, b into shift registers, carry reg <= cin, bit counter <= 0, go RUN.
REQ-017 In RUN, one bit per cycle LSB-first: s = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0], b_sr[0], c); a_sr, b_sr shift right; sum_sr <= {s, sum_sr[7:1]}; counter increments.
REQ-018 RUN SHALL last exactly 8 edges; on the 8th RUN edge go DONE with sum = sum_sr and cout = final carry.
REQ-019 Latency: out_valid SHALL be high in the cycle following the 8th edge after the accept edge.
REQ-020 In DONE: out_valid=1, in_ready=0; sum/cout SHALL remain stable until out_valid && out_ready.
REQ-021 On out_valid && out_ready go IDLE; out_valid low next cycle.
REQ-022 Throughput with in_valid and out_ready held high: one accept every 10 cycles.
REQ-023 in_ready=0 in RUN and DONE; in_valid there SHALL be ignored and operands not sampled.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 Arithmetic: {cout, sum} SHALL equal (a + b + cin) mod 512 for all 2^17 input combinations.
REQ-026 sum/cout SHALL retain the last result in IDLE until overwritten by the next completed operation.

Reset
REQ-027 rst high at an edge SHALL force IDLE regardless of state, including mid-RUN and DONE.
REQ-028 Post-reset values: in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0; shift regs, carry, counter cleared.
REQ-029 An operation in flight at reset SHALL be discarded, no out_valid pulse.
REQ-030 rst high with in_valid high SHALL not accept; first accept possible at first edge with rst low.

Verification
REQ-031 a=0x01, b=0x01, cin=0 -> out_valid 8 cycles after accept, sum=0x02, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-033 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 out_ready low for 5 cycles in DONE, in_valid high with a=0x55 -> out_valid held, sum/cout stable, in_ready=0, 0x55 not sampled; completes on out_ready.
REQ-035 rst at 4th RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0x00, cout=0; then a=0x10, b=0x20, cin=0 -> sum=0x30, cout=0.
REQ-036 in_valid and out_ready tied high, 3 operations -> accepts exactly 10 cycles apart, all results correct; plus random sweep of a, b, cin vs reference model.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial 8-bit adder: operands are captured on a valid/ready handshake and
// added LSB-first over eight cycles; the 9-bit result is held until consumed.
module serial_adder_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sum,
    output logic       cout,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_sr_q, a_sr_d;
    logic [7:0] b_sr_q, b_sr_d;
    logic [7:0] sum_sr_q, sum_sr_d;
    logic [7:0] sum_q, sum_d;
    logic [2:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic       cout_q, cout_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       bit_s;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        bit_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = 3'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
                carry_d  = majority(a_sr_q[0], b_sr_q[0], carry_q);
                a_sr_d   = {1'b0, a_sr_q[7:1]};
                b_sr_d   = {1'b0, b_sr_q[7:1]};
                sum_sr_d = {bit_s, sum_sr_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                // Last bit: publish the completed shift register and final carry together.
                if (cnt_q == 3'd7) begin
                    sum_d   = sum_sr_d;
                    cout_d  = carry_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sr_q      <= 8'h00;
            b_sr_q      <= 8'h00;
            sum_sr_q    <= 8'h00;
            sum_q       <= 8'h00;
            cnt_q       <= 3'd0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
